// File: rtl/dual_port_ram_param.sv
// Parametrised synchronous RAM with one write port and one read port.
// Byte-lane write enables, 1- or 2-cycle read latency with a valid strobe,
// selectable read-during-write behaviour and a post-reset clear sweep that
// writes INIT_VALUE to every location before the ports come alive.
module dual_port_ram_param #(
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           ADDR_WIDTH   = 8,
    parameter int unsigned           DEPTH        = 2 ** ADDR_WIDTH,
    parameter int unsigned           READ_LATENCY = 1,
    parameter bit                    WRITE_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    init_busy,
    input  logic                    write_en,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    read_en,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    read_valid
);

    localparam int unsigned           NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Parameter sanity: refuse to elaborate an unsupported configuration.
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $fatal(1, "dual_port_ram_param: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "dual_port_ram_param: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
        $fatal(1, "dual_port_ram_param: DEPTH exceeds address space");
    end

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic                    ready;

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   lane_mask;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NUM_LANES-1:0]    mem_be;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [DATA_WIDTH-1:0]   rd_old;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    collide;

    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic                    s1_valid_q;

    // Clear sweep state register and address counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StClear;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Sweep sequencing: one location per edge, leave after the last one.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StClear: begin
                count_d = count_q + 1'b1;
                if (count_q == LAST_ADDR) begin
                    state_d = StReady;
                    count_d = '0;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StClear;
                count_d = '0;
            end
        endcase
    end

    assign ready     = (state_q == StReady);
    assign init_busy = ~ready;

    assign wr_in_range = ({1'b0, write_address} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, read_address} < DEPTH_EXT);
    assign wr_fire     = ready && write_en && (|byte_en) && wr_in_range;
    assign rd_fire     = ready && read_en;

    // Expand byte enables into a bit mask for merging.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_mask[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    // The array's single write port is shared between the sweep and the user.
    always_comb begin
        if (!ready) begin
            mem_we    = 1'b1;
            mem_addr  = count_q;
            mem_wdata = INIT_VALUE;
            mem_be    = '1;
        end else begin
            mem_we    = wr_fire;
            mem_addr  = write_address;
            mem_wdata = data_in;
            mem_be    = byte_en;
        end
    end

    // Storage array, no reset: the sweep initialises it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-side word selection, including same-address write bypass.
    always_comb begin
        rd_old  = rd_in_range ? mem[read_address] : '0;
        // wr_fire already implies the shared address is in range.
        collide = wr_fire && (read_address == write_address);
        if (WRITE_FIRST && collide) begin
            rd_data = (rd_old & ~lane_mask) | (data_in & lane_mask);
        end else begin
            rd_data = rd_old;
        end
    end

    // First read stage: captures the word on the accepting edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_data;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_valid_q;

        // Extra output register; data only moves when a read completes.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign data_out   = s2_data_q;
        assign read_valid = s2_valid_q;
    end else begin : g_lat1
        assign data_out   = s1_data_q;
        assign read_valid = s1_valid_q;
    end

endmodule
